branch_resolve_unit: RTL and testbench

Parametrised successor to the single-cycle branch comparator. It resolves conditional branches and JAL/JALR in EX, detects mispredictions against the fetch-stage prediction, and issues a registered flush/redirect to the front end. It also owns a 2-bit saturating branch history table (BHT) that predicts direction at fetch, plus branch and mispredict performance counters. It sits between the EX stage and the PC-select logic in the pipelined core.

---
 rtl/br_pkg.sv | 31 +++
 rtl/br_cmp.sv | 44 ++++
 rtl/branch_resolve_unit.sv | 113 +++++++++++
 tb/tb_branch_resolve_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and constants for the branch resolve unit: branch condition
// encoding, control-flow opcodes and the 2-bit BHT counter with its
// saturating update helpers.
package br_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5
  } br_type_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef logic [1:0] bht_cnt_t;

  // Count towards strongly taken, sticking at 2'b11.
  function automatic bht_cnt_t sat_inc(input bht_cnt_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  // Count towards strongly not-taken, sticking at 2'b00.
  function automatic bht_cnt_t sat_dec(input bht_cnt_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/br_cmp.sv
// Combinational branch comparator. A single XLEN+1 bit subtraction yields
// equality, signed less-than and unsigned less-than; br_type selects which
// of them (or its complement) becomes the branch condition.
module br_cmp
  import br_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      br_type,
  output logic            cond
);

  logic [XLEN:0] diff;
  logic          eq;
  logic          ovf;
  logic          lt;
  logic          ltu;

  assign diff = {1'b0, rs1} - {1'b0, rs2};
  assign eq   = (diff[XLEN-1:0] == '0);
  // Signed overflow: operands of differing sign and the result sign
  // disagrees with rs1.
  assign ovf  = (rs1[XLEN-1] ^ rs2[XLEN-1]) & (diff[XLEN-1] ^ rs1[XLEN-1]);
  assign lt   = diff[XLEN-1] ^ ovf;
  assign ltu  = diff[XLEN];

  // Select the condition for the branch type; types 6/7 never take.
  always_comb begin
    // NOTE: default assigned first so no path leaves cond unassigned (no latch).
    cond = 1'b0;
    case (br_type)
      BEQ:     cond = eq;
      BNE:     cond = ~eq;
      BLT:     cond = lt;
      BGE:     cond = ~lt;
      BLTU:    cond = ltu;
      BGEU:    cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches and jumps in EX, raises a registered
// flush/redirect on mispredict, maintains the 2-bit BHT used for the fetch
// prediction and counts resolved branches and mispredictions.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int       XLEN        = 32,
  parameter int       BHT_ENTRIES = 16,
  parameter bht_cnt_t CNT_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic [XLEN-1:0] pc_if_i,
  output logic            pred_taken_if_o,
  input  logic            valid_ex_i,
  input  logic [6:0]      opcode_ex_i,
  input  logic [2:0]      br_type_ex_i,
  input  logic [XLEN-1:0] rs1_ex_i,
  input  logic [XLEN-1:0] rs2_ex_i,
  input  logic [XLEN-1:0] pc_ex_i,
  input  logic [XLEN-1:0] target_ex_i,
  input  logic            pred_taken_ex_i,
  output logic            br_taken_o,
  output logic            flush_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            perf_clr_i,
  output logic [XLEN-1:0] br_cnt_o,
  output logic [XLEN-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bht_cnt_t         bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond;
  logic             is_br;
  logic             is_jmp;
  logic             act_taken;
  logic             res;
  logic             mis;
  logic             unused_pc_if_bits;

  // Only the word-index bits of the fetch PC address the table.
  assign unused_pc_if_bits = ^{pc_if_i[XLEN-1:IDX_W+2], pc_if_i[1:0]};

  assign if_idx = pc_if_i[IDX_W+1:2];
  assign ex_idx = pc_ex_i[IDX_W+1:2];

  br_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1     (rs1_ex_i),
    .rs2     (rs2_ex_i),
    .br_type (br_type_ex_i),
    .cond    (cond)
  );

  // Classify the EX instruction and decide whether it resolves this cycle;
  // anything in EX while a flush is outstanding is wrong-path.
  always_comb begin
    is_br     = (opcode_ex_i == OP_BRANCH);
    is_jmp    = (opcode_ex_i == OP_JAL) || (opcode_ex_i == OP_JALR);
    act_taken = is_jmp ? 1'b1 : (is_br ? cond : 1'b0);
    res       = valid_ex_i & ~stall_i & ~flush_o & (is_br | is_jmp);
    mis       = res & (act_taken != pred_taken_ex_i);
  end

  // Fetch prediction reads the stored counter; a same-cycle EX update is
  // not bypassed.
  assign pred_taken_if_o = bht[if_idx][1];

  // Train the BHT with the outcome of resolved conditional branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is a handful of flops, not a RAM, so every entry
      // takes a known reset value instead of being left undefined.
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_INIT;
    end else if (res && is_br) begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      bht[ex_idx] <= act_taken ? sat_inc(bht[ex_idx]) : sat_dec(bht[ex_idx]);
    end
  end

  // Registered resolve outcome: flush pulse, taken flag and redirect PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_o       <= 1'b0;
      br_taken_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      flush_o    <= mis;
      br_taken_o <= res & act_taken;
      if (mis) begin
        redirect_pc_o <= act_taken ? target_ex_i : pc_ex_i + XLEN'(4);
      end
    end
  end

  // Performance counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_o      <= '0;
      mispred_cnt_o <= '0;
    end else if (perf_clr_i) begin
      br_cnt_o      <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (res) br_cnt_o      <= br_cnt_o + XLEN'(1);
      if (mis) mispred_cnt_o <= mispred_cnt_o + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed
// by randomized traffic, all compared against a behavioural reference model.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int N    = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall_i;
  logic [XLEN-1:0] pc_if_i;
  logic            pred_taken_if_o;
  logic            valid_ex_i;
  logic [6:0]      opcode_ex_i;
  logic [2:0]      br_type_ex_i;
  logic [XLEN-1:0] rs1_ex_i;
  logic [XLEN-1:0] rs2_ex_i;
  logic [XLEN-1:0] pc_ex_i;
  logic [XLEN-1:0] target_ex_i;
  logic            pred_taken_ex_i;
  logic            br_taken_o;
  logic            flush_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            perf_clr_i;
  logic [XLEN-1:0] br_cnt_o;
  logic [XLEN-1:0] mispred_cnt_o;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (N),
    .CNT_INIT    (2'b01)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .pc_if_i         (pc_if_i),
    .pred_taken_if_o (pred_taken_if_o),
    .valid_ex_i      (valid_ex_i),
    .opcode_ex_i     (opcode_ex_i),
    .br_type_ex_i    (br_type_ex_i),
    .rs1_ex_i        (rs1_ex_i),
    .rs2_ex_i        (rs2_ex_i),
    .pc_ex_i         (pc_ex_i),
    .target_ex_i     (target_ex_i),
    .pred_taken_ex_i (pred_taken_ex_i),
    .br_taken_o      (br_taken_o),
    .flush_o         (flush_o),
    .redirect_pc_o   (redirect_pc_o),
    .perf_clr_i      (perf_clr_i),
    .br_cnt_o        (br_cnt_o),
    .mispred_cnt_o   (mispred_cnt_o)
  );

  localparam logic [6:0] OPB  = 7'b1100011;
  localparam logic [6:0] OPJ  = 7'b1101111;
  localparam logic [6:0] OPJR = 7'b1100111;
  localparam logic [6:0] OPX  = 7'b0110011;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_bht [N];
  bit          m_flush;
  bit          m_taken;
  logic [31:0] m_redir;
  logic [31:0] m_br;
  logic [31:0] m_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("comparison %s", tag);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return $signed(a) < $signed(b);
      3'd3:    return $signed(a) >= $signed(b);
      3'd4:    return a < b;
      3'd5:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_bht[i] = 1;
    m_flush = 0;
    m_taken = 0;
    m_redir = '0;
    m_br    = '0;
    m_mis   = '0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit is_br, is_jmp, act, res, mis;
    int i;
    is_br  = (opcode_ex_i == OPB);
    is_jmp = (opcode_ex_i == OPJ) || (opcode_ex_i == OPJR);
    act    = is_jmp ? 1'b1 : (is_br ? ref_cond(br_type_ex_i, rs1_ex_i, rs2_ex_i) : 1'b0);
    res    = valid_ex_i && !stall_i && !m_flush && (is_br || is_jmp);
    mis    = res && (act != pred_taken_ex_i);
    if (res && is_br) begin
      i = idx_of(pc_ex_i);
      if (act && m_bht[i] < 3) m_bht[i]++;
      if (!act && m_bht[i] > 0) m_bht[i]--;
    end
    if (mis) m_redir = act ? target_ex_i : pc_ex_i + 32'd4;
    if (perf_clr_i) begin
      m_br  = '0;
      m_mis = '0;
    end else begin
      m_br  = m_br + 32'(res);
      m_mis = m_mis + 32'(mis);
    end
    m_flush = mis;
    m_taken = res && act;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input bit v, input logic [6:0] op, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] tgt, input bit pred);
    valid_ex_i      = v;
    opcode_ex_i     = op;
    br_type_ex_i    = t;
    rs1_ex_i        = a;
    rs2_ex_i        = b;
    pc_ex_i         = pc;
    target_ex_i     = tgt;
    pred_taken_ex_i = pred;
  endtask

  task automatic idle();
    set_ex(0, OPX, 3'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_flush"}, flush_o, m_flush);
    check({tag, "_taken"}, br_taken_o, m_taken);
    check({tag, "_redir"}, redirect_pc_o, m_redir);
    check({tag, "_brcnt"}, br_cnt_o, m_br);
    check({tag, "_miscnt"}, mispred_cnt_o, m_mis);
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc);
    pc_if_i = pc;
    #1;
    check(tag, pred_taken_if_o, 32'((m_bht[idx_of(pc)] >> 1) & 1));
  endtask

  initial begin
    logic [31:0] br0, mis0;
    int          r;
    logic [6:0]  ops [4];
    ops[0] = OPB; ops[1] = OPJ; ops[2] = OPJR; ops[3] = OPX;

    rst_n = 1'b0;
    stall_i = 1'b0;
    perf_clr_i = 1'b0;
    pc_if_i = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check_pred("reset_pred", 32'h100);
    rst_n = 1'b1;

    // Taken BEQ predicted not-taken
    set_ex(1, OPB, 3'd0, 5, 5, 32'h100, 32'h140, 0);
    tick();
    check_all("beq");
    check("beq_flush_k", flush_o, 1);
    check("beq_redir_k", redirect_pc_o, 32'h140);
    check("beq_taken_k", br_taken_o, 1);
    idle();
    check_pred("beq_pred", 32'h100);
    check("beq_pred_k", pred_taken_if_o, 1);
    tick();
    check_all("beq_after");

    // Signed vs unsigned compare of 0xFFFFFFFF and 1
    set_ex(1, OPB, 3'd2, 32'hFFFF_FFFF, 1, 32'h10, 32'h300, 1);
    tick();
    check_all("blt");
    check("blt_flush_k", flush_o, 0);
    check("blt_taken_k", br_taken_o, 1);
    set_ex(1, OPB, 3'd4, 32'hFFFF_FFFF, 1, 32'h14, 32'h300, 1);
    tick();
    check_all("bltu");
    check("bltu_flush_k", flush_o, 1);
    check("bltu_redir_k", redirect_pc_o, 32'h18);
    idle();
    tick();

    // Saturation at pc 0x40
    for (int i = 0; i < 4; i++) begin
      set_ex(1, OPB, 3'd1, 1, 2, 32'h40, 32'h80, 1);
      tick();
      check_all("bne_sat");
    end
    set_ex(1, OPB, 3'd1, 3, 3, 32'h40, 32'h80, 1);
    check_pred("bne_sat_pred", 32'h40);
    tick();
    check_all("bne_nt");
    idle();
    check_pred("bne_nt_pred", 32'h40);
    check("bne_nt_pred_k", pred_taken_if_o, 1);
    tick();

    // Mispredicted JALR followed by a wrong-path BEQ
    br0 = m_br;
    mis0 = m_mis;
    set_ex(1, OPJR, 3'd0, 0, 0, 32'h200, 32'h80, 0);
    tick();
    check_all("jalr");
    check("jalr_flush_k", flush_o, 1);
    check("jalr_redir_k", redirect_pc_o, 32'h80);
    set_ex(1, OPB, 3'd0, 7, 7, 32'h44, 32'h90, 0);
    tick();
    check_all("wrongpath");
    check("wrongpath_flush_k", flush_o, 0);
    check("wrongpath_br_k", br_cnt_o - br0, 1);
    check("wrongpath_mis_k", mispred_cnt_o - mis0, 1);
    idle();
    check_pred("wrongpath_pred", 32'h44);
    check("wrongpath_pred_k", pred_taken_if_o, 0);
    tick();

    // Mispredict held under stall for 3 cycles
    br0 = m_br;
    mis0 = m_mis;
    set_ex(1, OPB, 3'd5, 9, 3, 32'h60, 32'h20, 0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall");
      check("stall_flush_k", flush_o, 0);
    end
    stall_i = 1'b0;
    tick();
    check_all("unstall");
    check("unstall_flush_k", flush_o, 1);
    idle();
    tick();
    check_all("unstall_after");
    check("unstall_br_k", br_cnt_o - br0, 1);
    check("unstall_mis_k", mispred_cnt_o - mis0, 1);

    // Clear with a same-cycle mispredict, then async reset mid-flush
    set_ex(1, OPJ, 3'd0, 0, 0, 32'h300, 32'h400, 0);
    perf_clr_i = 1'b1;
    tick();
    check_all("clr");
    check("clr_mis_k", mispred_cnt_o, 0);
    check("clr_flush_k", flush_o, 1);
    perf_clr_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst_flush_k", flush_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    check_pred("rst_pred", 32'h40);
    check("rst_pred_k", pred_taken_if_o, 0);
    tick();
    check_all("rst_after");

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 3));
      set_ex($urandom_range(0, 9) != 0, ops[r], 3'($urandom_range(0, 7)),
             $urandom(), 32'h0, 32'($urandom_range(0, 63)) << 2, $urandom(),
             1'($urandom_range(0, 1)));
      rs2_ex_i = ($urandom_range(0, 3) == 0) ? rs1_ex_i : $urandom();
      stall_i = ($urandom_range(0, 4) == 0);
      perf_clr_i = ($urandom_range(0, 30) == 0);
      check_pred("rnd_pred", 32'($urandom_range(0, 255)) << 2);
      tick();
      check_all("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
